// File: rtl/audio_serial_port_transceiver.sv
// audio_serial_port_transceiver: BCLK/LRCK master with LJ or I2S DAC
// serialiser and ADC deserialiser for the WM8731 audio path.
module audio_serial_port_transceiver #(
  parameter int CLK_RATE_HZ = 50000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int FORMAT      = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  output logic                   BUSY,
  input  logic [SAMPLE_BITS-1:0] DAC_LCHAN_DATA,
  input  logic [SAMPLE_BITS-1:0] DAC_RCHAN_DATA,
  output logic                   DAC_LCHAN_TRIG,
  output logic                   DAC_RCHAN_TRIG,
  output logic [SAMPLE_BITS-1:0] ADC_LCHAN_DATA,
  output logic [SAMPLE_BITS-1:0] ADC_RCHAN_DATA,
  output logic                   ADC_LCHAN_READY,
  output logic                   ADC_RCHAN_READY,
  output logic                   AUD_BCLK,
  output logic                   AUD_DACLRCK,
  output logic                   AUD_ADCLRCK,
  output logic                   AUD_DACDAT,
  input  logic                   AUD_ADCDAT,
  output logic                   LAD_AUD_BCLK,
  output logic                   LAD_AUD_DACLRCK,
  output logic                   LAD_AUD_DACDAT,
  output logic                   LAD_AUD_ADCLRCK,
  output logic                   LAD_AUD_ADCDAT
);

  localparam int SB = SAMPLE_BITS;
  localparam int S  = SLOT_BITS;
  localparam int D  = FORMAT;
  localparam int BCLK_HALF = CLK_RATE_HZ / (SAMPLE_RATE * 4 * SLOT_BITS);
  localparam int HW = (BCLK_HALF >= 2) ? $clog2(BCLK_HALF) : 1;
  localparam int BW = $clog2(2 * S);

  localparam logic [HW-1:0] HC_LAST   = HW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] BI_LAST   = BW'(2 * S - 1);
  localparam logic [BW-1:0] BI_RSTART = BW'(S);
  localparam logic          L_LVL     = (FORMAT == 0);

  if (BCLK_HALF < 2) begin : g_chk_div
    $error("BCLK_HALF must be at least 2");
  end
  if (SLOT_BITS < SAMPLE_BITS + FORMAT) begin : g_chk_slot
    $error("SLOT_BITS too small for SAMPLE_BITS and FORMAT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hc_q, hc_d;
  logic [BW-1:0]    bi_q, bi_d;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;
  logic             dac_q, dac_d;
  logic [SB-1:0]    tx_q, tx_d;
  logic [SB-1:0]    rx_q, rx_d;
  logic [SB-1:0]    adc_l_q, adc_l_d;
  logic [SB-1:0]    adc_r_q, adc_r_d;
  logic             trig_l_q, trig_l_d;
  logic             trig_r_q, trig_r_d;
  logic             rdy_l_q, rdy_l_d;
  logic             rdy_r_q, rdy_r_d;

  logic [BW-1:0]    nxt_bi;
  logic [BW-1:0]    cur_p;
  logic [BW-1:0]    nxt_p;
  logic [SB-1:0]    src;
  logic             hc_term;
  logic             rise;
  logic             fall;
  logic             in_data;

  function automatic logic [BW-1:0] pos(input logic [BW-1:0] b);
    return (b >= BI_RSTART) ? b - BI_RSTART : b;
  endfunction

  // Bit sent at slot position p; zero outside the data window.
  function automatic logic tx_bit(input logic [SB-1:0] s,
                                  input logic [BW-1:0] p);
    logic b;
    b = 1'b0;
    for (int k = 0; k < SB; k++)
      if (int'(p) == k + D) b = s[SB-1-k];
    return b;
  endfunction

  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    bclk_d   = bclk_q;
    bi_d     = bi_q;
    lrck_d   = lrck_q;
    dac_d    = dac_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    adc_l_d  = adc_l_q;
    adc_r_d  = adc_r_q;
    trig_l_d = 1'b0;
    trig_r_d = 1'b0;
    rdy_l_d  = 1'b0;
    rdy_r_d  = 1'b0;
    src      = tx_q;
    nxt_bi   = (bi_q == BI_LAST) ? '0 : bi_q + 1'b1;
    cur_p    = pos(bi_q);
    nxt_p    = pos(nxt_bi);
    hc_term  = (hc_q == HC_LAST);
    rise     = hc_term & ~bclk_q;
    fall     = hc_term & bclk_q;
    in_data  = (int'(cur_p) >= D) && (int'(cur_p) < D + SB);
    case (state_q)
      IDLE: begin
        if (ENABLE) begin
          state_d  = RUN;
          hc_d     = '0;
          bclk_d   = 1'b0;
          bi_d     = '0;
          lrck_d   = L_LVL;
          tx_d     = DAC_LCHAN_DATA;
          trig_l_d = 1'b1;
          dac_d    = tx_bit(DAC_LCHAN_DATA, '0);
        end
      end
      RUN, DRAIN: begin
        if (state_q == RUN && !ENABLE) state_d = DRAIN;
        hc_d = hc_term ? '0 : hc_q + 1'b1;
        if (hc_term) bclk_d = ~bclk_q;
        if (rise && in_data) begin
          rx_d = {rx_q[SB-2:0], AUD_ADCDAT};
          if (int'(cur_p) == D + SB - 1) begin
            if (bi_q < BI_RSTART) begin
              adc_l_d = rx_d;
              rdy_l_d = 1'b1;
            end else begin
              adc_r_d = rx_d;
              rdy_r_d = 1'b1;
            end
          end
        end
        if (fall) begin
          if (state_q == DRAIN && bi_q == BI_LAST) begin
            state_d = IDLE;
            hc_d    = '0;
            bclk_d  = 1'b0;
            bi_d    = '0;
            lrck_d  = 1'b0;
            dac_d   = 1'b0;
          end else begin
            bi_d   = nxt_bi;
            lrck_d = (nxt_bi < BI_RSTART) ? L_LVL : ~L_LVL;
            if (nxt_bi == '0) begin
              src      = DAC_LCHAN_DATA;
              tx_d     = src;
              trig_l_d = 1'b1;
            end else if (nxt_bi == BI_RSTART) begin
              src      = DAC_RCHAN_DATA;
              tx_d     = src;
              trig_r_d = 1'b1;
            end
            dac_d = tx_bit(src, nxt_p);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      hc_q     <= '0;
      bclk_q   <= 1'b0;
      bi_q     <= '0;
      lrck_q   <= 1'b0;
      dac_q    <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      adc_l_q  <= '0;
      adc_r_q  <= '0;
      trig_l_q <= 1'b0;
      trig_r_q <= 1'b0;
      rdy_l_q  <= 1'b0;
      rdy_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      bclk_q   <= bclk_d;
      bi_q     <= bi_d;
      lrck_q   <= lrck_d;
      dac_q    <= dac_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      adc_l_q  <= adc_l_d;
      adc_r_q  <= adc_r_d;
      trig_l_q <= trig_l_d;
      trig_r_q <= trig_r_d;
      rdy_l_q  <= rdy_l_d;
      rdy_r_q  <= rdy_r_d;
    end
  end

  assign BUSY            = (state_q != IDLE);
  assign DAC_LCHAN_TRIG  = trig_l_q;
  assign DAC_RCHAN_TRIG  = trig_r_q;
  assign ADC_LCHAN_DATA  = adc_l_q;
  assign ADC_RCHAN_DATA  = adc_r_q;
  assign ADC_LCHAN_READY = rdy_l_q;
  assign ADC_RCHAN_READY = rdy_r_q;
  assign AUD_BCLK        = bclk_q;
  assign AUD_DACLRCK     = lrck_q;
  assign AUD_ADCLRCK     = lrck_q;
  assign AUD_DACDAT      = dac_q;
  assign LAD_AUD_BCLK    = bclk_q;
  assign LAD_AUD_DACLRCK = lrck_q;
  assign LAD_AUD_DACDAT  = dac_q;
  assign LAD_AUD_ADCLRCK = lrck_q;
  assign LAD_AUD_ADCDAT  = AUD_ADCDAT;

endmodule
